// File: rtl/aoc_pkg.sv
// Shared constants for the array order checker: FSM encodings and mode bit positions.
package aoc_pkg;

  typedef logic [1:0] aoc_state_t;

  localparam aoc_state_t ST_IDLE   = 2'd0;
  localparam aoc_state_t ST_PRIME  = 2'd1;
  localparam aoc_state_t ST_SCAN   = 2'd2;
  localparam aoc_state_t ST_FINISH = 2'd3;

  localparam int MODE_DESC   = 0;
  localparam int MODE_STRICT = 1;
  localparam int MODE_STOP   = 2;

endpackage

// File: rtl/aoc_pair_compare.sv
// Decides whether an adjacent (prev, cur) pair breaks the requested ordering.
module aoc_pair_compare #(
  parameter int DATA_W = 32,
  parameter int SIGNED = 0
) (
  input  logic [DATA_W-1:0] prev,
  input  logic [DATA_W-1:0] cur,
  input  logic              desc,
  input  logic              strict,
  output logic              inverted
);

  logic gt;
  logic eq;

  generate
    if (SIGNED != 0) begin : g_signed
      assign gt = $signed(prev) > $signed(cur);
    end else begin : g_unsigned
      assign gt = prev > cur;
    end
  endgenerate

  assign eq = (prev == cur);

  // Descending is the mirror of ascending: p<c is !(p>c) && !(p==c).
  always_comb begin
    inverted = 1'b0;
    case ({desc, strict})
      2'b00:   inverted = gt;
      2'b01:   inverted = gt | eq;
      2'b10:   inverted = ~gt & ~eq;
      default: inverted = ~gt;
    endcase
  end

endmodule

// File: rtl/array_order_checker.sv
// Self-sequenced order checker: streams base..base+length-1 from a sync-read memory
// and reports sortedness, first inversion index and a saturating inversion count.
//
// state  | meaning
// IDLE   | waiting for start; results from the last scan held
// PRIME  | read of element 0 on the bus
// SCAN   | element k data returning, read of k+1 on the bus
// FINISH | results final, done pulse
module array_order_checker
  import aoc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   length,
  input  logic [2:0]        mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              sorted,
  output logic [ADDR_W:0]   inv_index,
  output logic [ADDR_W:0]   inv_count
);

  localparam int CW = ADDR_W + 1;

  aoc_state_t        state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [2:0]        mode_q, mode_d;
  logic [CW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              sorted_q, sorted_d;
  logic [CW-1:0]     inv_index_q, inv_index_d;
  logic [CW-1:0]     inv_count_q, inv_count_d;

  logic inverted;
  logic pair_inv;
  logic finish;
  logic more_reads;

  aoc_pair_compare #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_cmp (
    .prev     (prev_q),
    .cur      (rd_data),
    .desc     (mode_q[MODE_DESC]),
    .strict   (mode_q[MODE_STRICT]),
    .inverted (inverted)
  );

  // Element 0 only primes prev, so it never forms a pair.
  assign pair_inv   = (k_q != '0) && inverted;
  assign finish     = (k_q == len_q - CW'(1)) || (pair_inv && mode_q[MODE_STOP]);
  // One bit wider so k+2 cannot overflow when length is at its maximum.
  assign more_reads = ({1'b0, k_q} + (CW+1)'(2)) < {1'b0, len_q};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    k_d         = k_q;
    prev_d      = prev_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    sorted_d    = sorted_q;
    inv_index_d = inv_index_q;
    inv_count_d = inv_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = length;
          mode_d      = mode;
          inv_index_d = '0;
          inv_count_d = '0;
          if (length < CW'(2)) begin
            state_d  = ST_FINISH;
            sorted_d = 1'b1;
          end else begin
            state_d   = ST_PRIME;
            sorted_d  = 1'b0;
            rd_en_d   = 1'b1;
            rd_addr_d = base;
          end
        end
      end

      ST_PRIME: begin
        state_d   = ST_SCAN;
        k_d       = '0;
        rd_en_d   = 1'b1;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
      end

      ST_SCAN: begin
        k_d    = k_q + CW'(1);
        prev_d = rd_data;
        if (pair_inv) begin
          if (inv_count_q != '1) inv_count_d = inv_count_q + CW'(1);
          if (inv_count_q == '0) inv_index_d = k_q - CW'(1);
        end
        if (finish) begin
          state_d  = ST_FINISH;
          sorted_d = (inv_count_d == '0);
        end else if (more_reads) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      k_q         <= '0;
      prev_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      sorted_q    <= 1'b0;
      inv_index_q <= '0;
      inv_count_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      k_q         <= k_d;
      prev_q      <= prev_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      sorted_q    <= sorted_d;
      inv_index_q <= inv_index_d;
      inv_count_q <= inv_count_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign sorted    = sorted_q;
  assign inv_index = inv_index_q;
  assign inv_count = inv_count_q;

endmodule

// File: tb/tb_array_order_checker.sv
// Directed bench: an unsigned and a signed checker share one memory and one stimulus stream.
module tb_array_order_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  base = '0;
  logic [5:0]  length = '0;
  logic [2:0]  mode = '0;

  logic        rd_en, busy, done, sorted;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic [5:0]  inv_index, inv_count;

  logic        s_rd_en, s_busy, s_done, s_sorted;
  logic [4:0]  s_rd_addr;
  logic [31:0] s_rd_data = '0;
  logic [5:0]  s_inv_index, s_inv_count;

  logic [31:0] mem [32];

  int nvec = 0;
  int nfail = 0;
  int done_cyc;
  int nreads;
  logic [4:0] addrs [64];
  logic       r_sorted, r_busy1, rs_sorted;
  logic [5:0] r_idx, r_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en)   rd_data   <= mem[rd_addr];
    if (s_rd_en) s_rd_data <= mem[s_rd_addr];
  end

  array_order_checker #(.DATA_W(32), .ADDR_W(5), .SIGNED(0)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .length(length), .mode(mode),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .sorted(sorted), .inv_index(inv_index), .inv_count(inv_count)
  );

  array_order_checker #(.DATA_W(32), .ADDR_W(5), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .base(base), .length(length), .mode(mode),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .busy(s_busy), .done(s_done),
    .sorted(s_sorted), .inv_index(s_inv_index), .inv_count(s_inv_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the accept cycle; pulse>0 re-pulses start in that cycle.
  task automatic run(input logic [4:0] b, input logic [5:0] l, input logic [2:0] m, input int pulse);
    @(posedge clk); #1;
    base = b; length = l; mode = m; start = 1'b1;
    nreads = 0; done_cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        r_busy1 = busy;
      end
      if (pulse != 0 && c == pulse) start = 1'b1;
      else if (pulse != 0 && c == pulse + 1) start = 1'b0;
      if (rd_en) begin
        if (nreads < 64) addrs[nreads] = rd_addr;
        nreads++;
      end
      if (done) begin
        done_cyc  = c;
        r_sorted  = sorted;
        r_idx     = inv_index;
        r_cnt     = inv_count;
        rs_sorted = s_sorted;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_run(input string tag, input int e_done, input int e_reads,
                         input logic e_sorted, input int e_idx, input int e_cnt);
    chk({tag, "_done_cyc"}, done_cyc, e_done);
    chk({tag, "_reads"}, nreads, e_reads);
    chk({tag, "_sorted"}, r_sorted, e_sorted);
    chk({tag, "_idx"}, r_idx, e_idx);
    chk({tag, "_cnt"}, r_cnt, e_cnt);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_sorted", sorted, 0);
    chk("rst_cnt", inv_count, 0);

    mem[0] = 1; mem[1] = 2; mem[2] = 2; mem[3] = 5; mem[4] = 9;
    run(5'd0, 6'd5, 3'b000, 0);
    chk_run("asc_sorted", 7, 5, 1'b1, 0, 0);
    chk("asc_busy1", r_busy1, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("asc_addr%0d", i), addrs[i], i);

    mem[0] = 3; mem[1] = 7; mem[2] = 4; mem[3] = 8; mem[4] = 1;
    run(5'd0, 6'd5, 3'b000, 0);
    chk_run("asc_two_inv", 7, 5, 1'b0, 1, 2);
    repeat (3) @(posedge clk);
    #1 chk("hold_cnt", inv_count, 2);
    chk("hold_sorted", sorted, 0);

    run(5'd0, 6'd5, 3'b100, 0);
    chk("stop_done_cyc", done_cyc, 5);
    chk("stop_cnt", r_cnt, 1);
    chk("stop_idx", r_idx, 1);

    run(5'd0, 6'd5, 3'b000, 3);
    chk_run("midstart", 7, 5, 1'b0, 1, 2);

    mem[0] = 4; mem[1] = 4;
    run(5'd0, 6'd2, 3'b000, 0);
    chk_run("eq_nonstrict", 4, 2, 1'b1, 0, 0);
    run(5'd0, 6'd2, 3'b010, 0);
    chk_run("eq_strict", 4, 2, 1'b0, 0, 1);

    mem[0] = 9; mem[1] = 5; mem[2] = 5; mem[3] = 0;
    run(5'd0, 6'd4, 3'b001, 0);
    chk_run("desc_nonstrict", 6, 4, 1'b1, 0, 0);
    run(5'd0, 6'd4, 3'b011, 0);
    chk_run("desc_strict", 6, 4, 1'b0, 1, 1);

    mem[30] = 10; mem[31] = 20; mem[0] = 5; mem[1] = 30;
    run(5'd30, 6'd4, 3'b000, 0);
    chk_run("wrap", 6, 4, 1'b0, 1, 1);
    chk("wrap_addr0", addrs[0], 30);
    chk("wrap_addr1", addrs[1], 31);
    chk("wrap_addr2", addrs[2], 0);
    chk("wrap_addr3", addrs[3], 1);

    run(5'd3, 6'd0, 3'b000, 0);
    chk_run("len0", 1, 0, 1'b1, 0, 0);
    run(5'd3, 6'd1, 3'b000, 0);
    chk_run("len1", 1, 0, 1'b1, 0, 0);

    // Abort mid-scan after one inversion has been counted.
    mem[0] = 3; mem[1] = 7; mem[2] = 4; mem[3] = 8; mem[4] = 1;
    @(posedge clk); #1;
    base = 5'd0; length = 6'd5; mode = 3'b000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("pre_reset_cnt", inv_count, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_rd_addr", rd_addr, 0);
    chk("abort_cnt", inv_count, 0);
    chk("abort_idx", inv_index, 0);
    chk("abort_sorted", sorted, 0);
    reset = 1'b0;
    run(5'd0, 6'd5, 3'b000, 0);
    chk_run("after_abort", 7, 5, 1'b0, 1, 2);

    mem[0] = 32'hFFFF_FFFD; mem[1] = 32'd2;
    run(5'd0, 6'd2, 3'b000, 0);
    chk("signed_sorted", rs_sorted, 1);
    chk("unsigned_neg_sorted", r_sorted, 0);
    chk("unsigned_neg_cnt", r_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
